// File: rtl/mux_pair_sequencer.sv
// mux_pair_sequencer
//
// Drives four 2-bit data pairs, one at a time, onto an external 2:1 mux.
// Each pair is held for HOLD cycles, and then the mux output is captured
// into the matching bit of result. When all four pairs are done, the
// block emits a one-cycle done pulse and returns to idle.
//
// Parameters
//   HOLD         cycles each pair is driven before mux_out is sampled (1..15)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request one 4-pair sequence (accepted when start && ready)
//   data_in      four pairs; pair k = data_in[2k+1:2k]
//   sel_pattern  per-pair select; pair k uses sel_pattern[k]
//   ready        high only while idle
//   mux_in       pair driven to the downstream mux
//   mux_sel      select driven to the downstream mux
//   mux_out      value returned by the downstream mux
//   result       result[k] = mux_out sampled for pair k
//   done         one-cycle pulse, result complete
module mux_pair_sequencer #(
  parameter int unsigned HOLD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic [3:0] sel_pattern,
  output logic       ready,
  output logic [1:0] mux_in,
  output logic       mux_sel,
  input  logic       mux_out,
  output logic [3:0] result,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] data_q, data_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] result_q, result_d;

  logic       ready_q, ready_d;
  logic [1:0] mux_in_q, mux_in_d;
  logic       mux_sel_q, mux_sel_d;
  logic       done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      hold_q    <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      result_q  <= '0;
      ready_q   <= 1'b1;
      mux_in_q  <= '0;
      mux_sel_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      hold_q    <= hold_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      mux_in_q  <= mux_in_d;
      mux_sel_q <= mux_sel_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    hold_d   = hold_q;
    data_d   = data_q;
    sel_d    = sel_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        // ready is high whenever the machine is idle, so only start matters here
        if (start) begin
          data_d   = data_in;
          sel_d    = sel_pattern;
          result_d = '0;
          k_d      = '0;
          hold_d   = '0;
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          result_d[k_q] = mux_out;
          hold_d        = '0;
          if (k_q == 2'd3) begin
            k_d     = '0;
            state_d = S_DONE;
          end else begin
            k_d = k_q + 2'd1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are computed from the next state and then registered, so every
    // output comes straight from a flop. The values are already correct in the
    // cycle in which that state is entered.
    ready_d   = (state_d == S_IDLE);
    done_d    = (state_d == S_DONE);
    mux_in_d  = '0;
    mux_sel_d = 1'b0;
    if (state_d == S_DRIVE) begin
      mux_in_d  = data_d[{k_d, 1'b0} +: 2];
      mux_sel_d = sel_d[k_d];
    end
  end

  assign ready   = ready_q;
  assign mux_in  = mux_in_q;
  assign mux_sel = mux_sel_q;
  assign result  = result_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mux_pair_sequencer.sv
`timescale 1ps/1ps
module tb_mux_pair_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] sel_pattern;
  logic       ready;
  logic [1:0] mux_in;
  logic       mux_sel;
  logic       mux_out;
  logic [3:0] result;
  logic       done;

  int total = 0;
  int bad   = 0;

  always #500 clk = ~clk;

  // downstream 2:1 mux
  assign mux_out = mux_in[mux_sel];

  mux_pair_sequencer #(.HOLD(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .sel_pattern(sel_pattern),
    .ready      (ready),
    .mux_in     (mux_in),
    .mux_sel    (mux_sel),
    .mux_out    (mux_out),
    .result     (result),
    .done       (done)
  );

  typedef struct {
    logic [7:0] d;
    logic [3:0] s;
    logic [3:0] r;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Accept at the edge after the first negedge (E0); sample mid-cycle 1..10.
  task automatic run_seq(input logic [7:0] d, input logic [3:0] s, input logic [3:0] r);
    int k;
    @(negedge clk);
    data_in = d; sel_pattern = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      k = (c - 1) / 2;
      chk("drive_mux_in", 32'(mux_in), 32'(d[2*k +: 2]));
      chk("drive_mux_sel", 32'(mux_sel), 32'(s[k]));
      chk("drive_ready", 32'(ready), 32'd0);
      chk("drive_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_ready", 32'(ready), 32'd0);
    chk("done_mux_in", 32'(mux_in), 32'd0);
    chk("done_mux_sel", 32'(mux_sel), 32'd0);
    chk("done_result", 32'(result), 32'(r));
    @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_result", 32'(result), 32'(r));
  endtask

  initial begin
    int          dones;
    logic [31:0] done_m, ready_m;

    vecs[0] = '{d: 8'b11_10_01_00, s: 4'b0101, r: 4'b1110};
    vecs[1] = '{d: 8'b11_10_01_00, s: 4'b1010, r: 4'b1000};
    vecs[2] = '{d: 8'hFF,          s: 4'b0000, r: 4'b1111};
    vecs[3] = '{d: 8'h00,          s: 4'b1111, r: 4'b0000};
    vecs[4] = '{d: 8'b01_10_01_10, s: 4'b0011, r: 4'b1001};
    vecs[5] = '{d: 8'b10_01_10_01, s: 4'b0110, r: 4'b0011};

    reset = 1'b1; start = 1'b0; data_in = '0; sel_pattern = '0;
    #200;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_mux_in", 32'(mux_in), 32'd0);
    chk("rst_mux_sel", 32'(mux_sel), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_seq(vecs[i].d, vecs[i].s, vecs[i].r);

    // asynchronous reset between edges while idle clears the held result
    @(negedge clk);
    chk("pre_async_result", 32'(result), 32'b0011);
    #100 reset = 1'b1;
    #100;
    chk("async_rst_result", 32'(result), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd1);
    // start while reset is high must not be taken
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("start_in_reset_ready", 32'(ready), 32'd1);
    chk("start_in_reset_mux_in", 32'(mux_in), 32'd0);

    // start toggling and data changes during DRIVE are ignored
    @(negedge clk);
    data_in = 8'b11_10_01_00; sel_pattern = 4'b0101; start = 1'b1;
    dones = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (c == 9) chk("ignore_result", 32'(result), 32'b1110);
      if (c <= 7) begin
        start = c[0];
        data_in = 8'($urandom);
        sel_pattern = 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    chk("ignore_done_count", 32'(dones), 32'd1);
    chk("ignore_result_held", 32'(result), 32'b1110);

    // reset in cycle 5 aborts the sequence
    @(negedge clk);
    data_in = 8'b11_10_01_00; sel_pattern = 4'b0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_c5_mux_in", 32'(mux_in), 32'b10);
    chk("abort_c5_result", 32'(result), 32'b0010);
    #100 reset = 1'b1;
    #100;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_mux_in", 32'(mux_in), 32'd0);
    chk("abort_mux_sel", 32'(mux_sel), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_seq(8'b11_10_01_00, 4'b1010, 4'b1000);

    // start held high: back-to-back sequences
    @(negedge clk);
    data_in = 8'b11_10_01_00; sel_pattern = 4'b0101; start = 1'b1;
    done_m = '0; ready_m = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      done_m[c]  = done;
      ready_m[c] = ready;
      if (done) chk("b2b_result", 32'(result), 32'b1110);
    end
    start = 1'b0;
    chk("b2b_done_cycles", done_m, (32'd1 << 9) | (32'd1 << 19) | (32'd1 << 29));
    chk("b2b_ready_cycles", ready_m, (32'd1 << 10) | (32'd1 << 20) | (32'd1 << 30));
    repeat (12) @(negedge clk);
    chk("b2b_final_ready", 32'(ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_pair_sequencer.md
MUX_PAIR_SEQUENCER -- requirements
Module: mux_pair_sequencer

Interface
REQ-001 SHALL have parameter: HOLD, 2, cycles each pair is driven before its mux output is sampled; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to run one 4-pair sequence.
REQ-005 SHALL have port: data_in  input  8  four 2-bit mux data pairs; pair k = data_in[2k+1:2k].
REQ-006 SHALL have port: sel_pattern  input  4  select value per pair; pair k uses sel_pattern[k].
REQ-007 SHALL have port: ready  output  1  high only when idle; start is accepted when start && ready.
REQ-008 SHALL have port: mux_in  output  2  data pair driven to the downstream 2:1 mux in[1:0].
REQ-009 SHALL have port: mux_sel  output  1  select driven to the downstream 2:1 mux.
REQ-010 SHALL have port: mux_out  input  1  output returned from the downstream 2:1 mux.
REQ-011 SHALL have port: result  output  4  result[k] = mux_out sampled for pair k.
REQ-012 SHALL have port: done  output  1  one-cycle pulse; result complete and valid.

Function
REQ-013 SHALL implement states IDLE, DRIVE, DONE; register-driven outputs only; no combinational path from any input to any output.
REQ-014 IDLE: ready=1, mux_in=2'b00, mux_sel=0, done=0; on start && ready at an edge, latch data_in and sel_pattern, clear result to 4'b0000, set pair index k=0 and hold counter=0, go to DRIVE.
REQ-015 start while not in IDLE SHALL be ignored; data_in and sel_pattern changes after acceptance SHALL have no effect on the running sequence.
REQ-016 DRIVE: mux_in = latched pair k, mux_sel = latched sel_pattern[k], ready=0, done=0; each pair is driven for exactly HOLD consecutive cycles.
REQ-017 At the edge ending the HOLD-th cycle of pair k, result[k] SHALL capture mux_out; other result bits unchanged.
REQ-018 After capturing pair k<3: k increments, hold counter resets, stay in DRIVE; after capturing pair 3: go to DONE.
REQ-019 DONE: lasts exactly one cycle; done=1, ready=0, mux_in=2'b00, mux_sel=0; then go to IDLE.
REQ-020 Latency: with acceptance at edge E0, pairs occupy cycles 1..4*HOLD after E0, done is high in cycle 4*HOLD+1, and ready returns high in cycle 4*HOLD+2.
REQ-021 result SHALL hold its value from DONE until the next accepted start; it SHALL NOT change in IDLE.
REQ-022 Back-to-back: start held high continuously SHALL start a new sequence on the first IDLE cycle; no IDLE cycle is skipped.
REQ-023 Hold counter and pair index SHALL wrap only via explicit reset to 0 (no modulo overflow); HOLD=1 SHALL give one-cycle pairs.
REQ-024 Latching at acceptance SHALL use the values of data_in and sel_pattern present in that same cycle.

Reset
REQ-025 reset high SHALL immediately, without waiting for clk, force IDLE: ready=1, mux_in=2'b00, mux_sel=0, result=4'b0000, done=0, k=0, hold counter=0.
REQ-026 reset asserted mid-sequence SHALL abort the sequence with no done pulse; the first start after reset deassertion SHALL be accepted normally.
REQ-027 start while reset is high SHALL be ignored.

Verification (HOLD=2, clk period 1000 ps, downstream 2:1 mux instantiated with mux_in/mux_sel/mux_out connected)
REQ-028 Reset: assert reset between edges -> outputs reach REQ-025 values before the next edge; ready=1.
REQ-029 data_in=8'b11_10_01_00, sel_pattern=4'b0101, pulse start -> mux_in 00,01,10,11 for 2 cycles each, mux_sel 1,0,1,0; done in cycle 9; result=4'b1110.
REQ-030 data_in=8'b11_10_01_00, sel_pattern=4'b1010 -> result=4'b1000; ready=1 in cycle 10.
REQ-031 start toggled and data_in changed during DRIVE -> ignored; result unchanged from latched values; exactly one done pulse.
REQ-032 reset asserted in cycle 5 of a sequence -> immediate IDLE, result=4'b0000, no done; the next start runs a full sequence.
REQ-033 start held high for 30 cycles -> done pulses in cycles 9, 19 and 29; ready high for exactly one cycle between sequences.
